// File: rtl/dmem_store_buffer_pkg.sv
// Shared types for the data-memory store buffer: word width, drain-state
// encoding and the buffered store entry.
package dmem_pkg;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } drain_state_t;

  // Byte offset is dropped on entry; only the word index is kept.
  typedef struct packed {
    logic [ADDR_W-3:0] word;
    logic [WORD_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/dmem_store_buffer_if.sv
// Bus bundle between the CPU data side, the store buffer and the backing RAM.
// The slave modport is the store buffer's view; master is the CPU/RAM side.
interface dmem_store_buffer_if #(
  parameter int AW    = 32,
  parameter int DEPTH = 4
) ();
  import dmem_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]     addr;
  logic [WORD_W-1:0] wdata;
  logic              wmem;
  logic              rmem;
  logic [WORD_W-1:0] rdata;
  logic              stall;
  // RAM write handshake: mreq is the valid, mack the ready. A write completes
  // on an edge where both are 1; maddr/mwdata stay stable while mreq=1 and
  // mack=0, and mack is ignored while mreq=0.
  logic              mreq;
  logic [AW-1:0]     maddr;
  logic [WORD_W-1:0] mwdata;
  logic              mack;
  logic [AW-1:0]     raddr;
  logic [WORD_W-1:0] mrdata;
  drain_state_t      dbg_state;
  logic [CW-1:0]     dbg_count;

  modport slave (
    input  addr, wdata, wmem, rmem, mack, mrdata,
    output rdata, stall, mreq, maddr, mwdata, raddr, dbg_state, dbg_count
  );

  modport master (
    output addr, wdata, wmem, rmem, mack, mrdata,
    input  rdata, stall, mreq, maddr, mwdata, raddr, dbg_state, dbg_count
  );
endinterface

// File: rtl/dmem_store_buffer_store_fifo.sv
// Circular store FIFO with per-entry valid bits and a parallel word-address
// match vector used for load forwarding / load hazard detection.
module store_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_push,
  input  entry_t               i_push_entry,
  input  logic                 i_pop,
  input  logic [ADDR_W-3:0]    i_lookup_word,
  output entry_t               o_head,
  output entry_t               o_head_next,
  output entry_t [DEPTH-1:0]   o_entries,
  output logic [DEPTH-1:0]     o_match,
  output logic [$clog2(DEPTH)-1:0] o_tail,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                 o_full,
  output logic                 o_empty
);
  localparam int PW = $clog2(DEPTH);

  entry_t [DEPTH-1:0] r_mem;
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [PW:0]        r_count;
  logic [DEPTH-1:0]   r_valid;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_tail] <= i_push_entry;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      // Push and pop never target the same slot: push is blocked when full
      // and pop needs a non-empty buffer.
      if (i_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (i_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_match[i] = r_valid[i] && (r_mem[i].word == i_lookup_word);
    end
  end

  assign o_head      = r_mem[r_head];
  assign o_head_next = r_mem[r_head + PW'(1)];
  assign o_entries   = r_mem;
  assign o_tail      = r_tail;
  assign o_count     = r_count;
  assign o_full      = (r_count == (PW+1)'(DEPTH));
  assign o_empty     = (r_count == '0);
endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between the CPU data port and a slow RAM: queues stores,
// drains them over mreq/mack, serves loads from the RAM async read port.
// Build option: STORE_FWD_EN adds newest-match forwarding from pending stores;
// without it a load hitting a pending store stalls until that store drains.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic resetn,
  dmem_store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  drain_state_t      r_state;
  logic              r_mreq;
  logic [AW-1:0]     r_maddr;
  logic [WORD_W-1:0] r_mwdata;

  entry_t             w_push_entry;
  entry_t             w_head;
  entry_t             w_head_next;
  entry_t             w_next;
  entry_t [DEPTH-1:0] w_entries;
  logic [DEPTH-1:0]   w_match;
  logic [PW-1:0]      w_tail;
  logic [PW:0]        w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_full_stall;
  logic               w_load_stall;
  logic               w_stall;

  assign w_push_entry = '{word: bus.addr[AW-1:2], data: bus.wdata};
  assign w_pop        = (r_state == BUSY) && bus.mack;
  assign w_push       = bus.wmem && !w_stall;

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk         (clock),
    .i_rst_n       (resetn),
    .i_push        (w_push),
    .i_push_entry  (w_push_entry),
    .i_pop         (w_pop),
    .i_lookup_word (bus.addr[AW-1:2]),
    .o_head        (w_head),
    .o_head_next   (w_head_next),
    .o_entries     (w_entries),
    .o_match       (w_match),
    .o_tail        (w_tail),
    .o_count       (w_count),
    .o_full        (w_full),
    .o_empty       (w_empty)
  );

  // Full is judged on the registered count, so a same-cycle pop does not help.
  assign w_full_stall = bus.wmem && w_full;

`ifdef STORE_FWD_EN
  logic              w_fwd_hit;
  logic [WORD_W-1:0] w_fwd_data;

  // Walk oldest to newest so the newest matching entry wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (w_match[w_tail - PW'(k)]) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_entries[w_tail - PW'(k)].data;
      end
    end
  end

  assign w_load_stall = 1'b0;
  assign bus.rdata    = w_fwd_hit ? w_fwd_data : bus.mrdata;
`else
  assign w_load_stall = bus.rmem && !bus.wmem && (|w_match);
  assign bus.rdata    = bus.mrdata;
`endif

  assign w_stall   = w_full_stall || w_load_stall;
  assign bus.stall = w_stall;
  assign bus.raddr = {bus.addr[AW-1:2], 2'b00};

  // When the last pending entry pops together with a push, the next head is
  // the entry being pushed, which is not in the array yet.
  assign w_next = (w_count == (PW+1)'(1)) ? w_push_entry : w_head_next;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_mreq   <= 1'b0;
      r_maddr  <= '0;
      r_mwdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state  <= BUSY;
            r_mreq   <= 1'b1;
            r_maddr  <= {w_head.word, 2'b00};
            r_mwdata <= w_head.data;
          end
        end
        BUSY: begin
          if (bus.mack) begin
            if ((w_count > (PW+1)'(1)) || w_push) begin
              r_maddr  <= {w_next.word, 2'b00};
              r_mwdata <= w_next.data;
            end else begin
              r_state <= IDLE;
              r_mreq  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_mreq  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mreq      = r_mreq;
  assign bus.maddr     = r_maddr;
  assign bus.mwdata    = r_mwdata;
  assign bus.dbg_state = r_state;
  assign bus.dbg_count = w_count;
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer; RAM writes are checked in order
// against an expected queue. Expectations follow the STORE_FWD_EN setting.
module tb_dmem_store_buffer;
  import dmem_pkg::*;

  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  dmem_store_buffer_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  dmem_store_buffer #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int          total    = 0;
  int          bad      = 0;
  int          n_writes = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // A write completes on the next rising edge when mreq and mack are both high.
  always @(negedge clock) begin
    if (resetn && bus.mreq && bus.mack) begin
      n_writes++;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        chk("write_order", {bus.maddr, bus.mwdata}, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.addr   = '0;
    bus.wdata  = '0;
    bus.wmem   = 1'b0;
    bus.rmem   = 1'b0;
    bus.mack   = 1'b0;
    bus.mrdata = '0;
  endtask

  task automatic drain_all(input string tag);
    bus.wmem = 1'b0;
    bus.rmem = 1'b0;
    bus.mack = 1'b1;
    for (int i = 0; i < 20 && bus.dbg_count != '0; i++) tick();
    chk({tag, "_count0"}, 64'(bus.dbg_count), 64'd0);
    chk({tag, "_mreq0"}, 64'(bus.mreq), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    resetn = 1'b0;
    tick();
    tick();
    chk("rst_mreq",   64'(bus.mreq),      64'd0);
    chk("rst_maddr",  64'(bus.maddr),     64'd0);
    chk("rst_mwdata", 64'(bus.mwdata),    64'd0);
    chk("rst_count",  64'(bus.dbg_count), 64'd0);
    chk("rst_state",  64'(bus.dbg_state), 64'(IDLE));
    chk("rst_stall",  64'(bus.stall),     64'd0);
    resetn = 1'b1;
    tick();

    // Single store with mack held high.
    bus.mack  = 1'b1;
    bus.wmem  = 1'b1;
    bus.addr  = 32'h40;
    bus.wdata = 32'hDEADBEEF;
    #1 chk("t1_stall", 64'(bus.stall), 64'd0);
    exp_q.push_back({32'h40, 32'hDEADBEEF});
    tick();
    bus.wmem = 1'b0;
    #1;
    chk("t1_count1", 64'(bus.dbg_count), 64'd1);
    chk("t1_mreq_lat", 64'(bus.mreq), 64'd0);
    tick();
    chk("t1_mreq", 64'(bus.mreq), 64'd1);
    chk("t1_maddr", 64'(bus.maddr), 64'h40);
    chk("t1_mwdata", 64'(bus.mwdata), 64'hDEADBEEF);
    tick();
    chk("t1_mreq_off", 64'(bus.mreq), 64'd0);
    chk("t1_count0", 64'(bus.dbg_count), 64'd0);
    chk("t1_nwr", 64'(n_writes), 64'd1);

    // Fill the buffer with mack low, then a fifth store must stall.
    bus.mack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wmem  = 1'b1;
      bus.addr  = 32'(i * 4);
      bus.wdata = 32'h100 + 32'(i);
      #1 chk("t2_fill_stall", 64'(bus.stall), 64'd0);
      exp_q.push_back({32'(i * 4), 32'h100 + 32'(i)});
      tick();
    end
    bus.addr  = 32'h10;
    bus.wdata = 32'h104;
    #1;
    chk("t2_full_stall", 64'(bus.stall), 64'd1);
    chk("t2_count4", 64'(bus.dbg_count), 64'd4);
    tick();
    chk("t2_still_stall", 64'(bus.stall), 64'd1);
    chk("t2_mreq", 64'(bus.mreq), 64'd1);
    chk("t2_maddr0", 64'(bus.maddr), 64'h0);
    bus.mack = 1'b1;
    #1 chk("t2_stall_with_mack", 64'(bus.stall), 64'd1);
    tick();
    chk("t2_count3", 64'(bus.dbg_count), 64'd3);
    chk("t2_maddr4", 64'(bus.maddr), 64'h4);
    chk("t2_unstall", 64'(bus.stall), 64'd0);
    exp_q.push_back({32'h10, 32'h104});
    tick();
    chk("t2_pushpop_count", 64'(bus.dbg_count), 64'd3);
    chk("t2_maddr8", 64'(bus.maddr), 64'h8);
    drain_all("t2");
    chk("t2_nwr", 64'(n_writes), 64'd6);

    // Asynchronous reset while a write is pending.
    bus.mack  = 1'b0;
    bus.wmem  = 1'b1;
    bus.addr  = 32'h50;
    bus.wdata = 32'h55;
    tick();
    bus.wmem = 1'b0;
    tick();
    chk("t3_mreq_pending", 64'(bus.mreq), 64'd1);
    resetn = 1'b0;
    #1;
    chk("t3_async_mreq", 64'(bus.mreq), 64'd0);
    chk("t3_async_count", 64'(bus.dbg_count), 64'd0);
    tick();
    resetn   = 1'b1;
    bus.mack = 1'b1;
    repeat (4) tick();
    chk("t3_no_write_mreq", 64'(bus.mreq), 64'd0);
    chk("t3_nwr", 64'(n_writes), 64'd6);

    // Load against one pending store.
    bus.mack  = 1'b0;
    bus.wmem  = 1'b1;
    bus.addr  = 32'h30;
    bus.wdata = 32'h33;
    exp_q.push_back({32'h30, 32'h33});
    tick();
    bus.wmem   = 1'b0;
    bus.rmem   = 1'b1;
    bus.addr   = 32'h33;
    bus.mrdata = 32'hAAAA5555;
    #1;
    chk("t4_raddr", 64'(bus.raddr), 64'h30);
`ifdef STORE_FWD_EN
    chk("t4_hit_stall", 64'(bus.stall), 64'd0);
    chk("t4_hit_rdata", 64'(bus.rdata), 64'h33);
`else
    chk("t4_hit_stall", 64'(bus.stall), 64'd1);
    chk("t4_hit_rdata", 64'(bus.rdata), 64'hAAAA5555);
`endif
    bus.addr = 32'h34;
    #1;
    chk("t4_miss_stall", 64'(bus.stall), 64'd0);
    chk("t4_miss_rdata", 64'(bus.rdata), 64'hAAAA5555);
    bus.addr = 32'h30;
    tick();
    tick();
    bus.mack = 1'b1;
    #1;
`ifdef STORE_FWD_EN
    chk("t4_pop_cycle_stall", 64'(bus.stall), 64'd0);
`else
    chk("t4_pop_cycle_stall", 64'(bus.stall), 64'd1);
`endif
    tick();
    chk("t4_count0", 64'(bus.dbg_count), 64'd0);
    chk("t4_after_stall", 64'(bus.stall), 64'd0);
    chk("t4_after_rdata", 64'(bus.rdata), 64'hAAAA5555);
    chk("t4_nwr", 64'(n_writes), 64'd7);

    // Two stores to the same word; the newer one must be seen by a load.
    bus.rmem = 1'b0;
    bus.mack = 1'b0;
    bus.wmem = 1'b1;
    bus.addr = 32'h20;
    bus.wdata = 32'h1;
    exp_q.push_back({32'h20, 32'h1});
    tick();
    bus.wdata = 32'h2;
    exp_q.push_back({32'h20, 32'h2});
    tick();
    bus.wmem   = 1'b0;
    bus.rmem   = 1'b1;
    bus.addr   = 32'h22;
    bus.mrdata = 32'h77;
    #1;
`ifdef STORE_FWD_EN
    chk("t5_newest_rdata", 64'(bus.rdata), 64'h2);
    chk("t5_hit_stall", 64'(bus.stall), 64'd0);
`else
    chk("t5_newest_rdata", 64'(bus.rdata), 64'h77);
    chk("t5_hit_stall", 64'(bus.stall), 64'd1);
`endif
    bus.addr = 32'h24;
    #1;
    chk("t5_miss_rdata", 64'(bus.rdata), 64'h77);
    chk("t5_miss_stall", 64'(bus.stall), 64'd0);
    drain_all("t5");
    chk("t5_nwr", 64'(n_writes), 64'd9);
    chk("exp_q_left", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
